// File: rtl/rv6_trap_pkg.sv
// rv6_trap_pkg: shared types and constants for the machine-mode trap sequencer.
package rv6_trap_pkg;

  localparam int XLEN = 64;

  // Trap sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_SAVE  = 3'd2,
    ST_RET   = 3'd3,
    ST_REDIR = 3'd4
  } trap_state_e;

  // Privilege levels
  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  // Machine interrupt codes
  localparam logic [5:0] IRQ_MSI = 6'd3;
  localparam logic [5:0] IRQ_MTI = 6'd7;
  localparam logic [5:0] IRQ_MEI = 6'd11;

  // mcause bit that marks an interrupt
  localparam int CAUSE_INT_BIT = 63;

  // Build an interrupt mcause value from a 6-bit interrupt code
  function automatic logic [XLEN-1:0] irq_cause(input logic [5:0] code);
    logic [XLEN-1:0] c;
    c = {58'd0, code};
    c[CAUSE_INT_BIT] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/trap_irq_prio.sv
// trap_irq_prio: fixed-priority machine interrupt selector, MEI > MSI > MTI.
// Only bits 11, 3 and 7 of the pending&enabled vector take part.
module trap_irq_prio
  import rv6_trap_pkg::*;
(
  input  logic [XLEN-1:0] pend,
  input  logic            en,
  output logic            valid,
  output logic [5:0]      code
);

  logic unused_s;
  assign unused_s = ^{pend[63:12], pend[10:8], pend[6:4], pend[2:0]};

  // Pick the highest-priority pending interrupt when interrupts are globally enabled
  always_comb begin
    valid = 1'b0;
    code  = 6'd0;
    if (!en) begin
      valid = 1'b0;
      code  = 6'd0;
    end else if (pend[11]) begin
      valid = 1'b1;
      code  = IRQ_MEI;
    end else if (pend[3]) begin
      valid = 1'b1;
      code  = IRQ_MSI;
    end else if (pend[7]) begin
      valid = 1'b1;
      code  = IRQ_MTI;
    end else begin
      valid = 1'b0;
      code  = 6'd0;
    end
  end

endmodule

// File: rtl/trap_ctl.sv
// trap_ctl: machine-mode trap / mret sequencer (FLUSH -> SAVE|RET -> REDIR).
// Optional feature macro: TRAP_VECTORED_EN (vectored interrupt targets when
// mtvec[1:0]==1); without it mtvec is always used in direct mode.
module trap_ctl
  import rv6_trap_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exc,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_val,
  input  logic            mret,
  input  logic [XLEN-1:0] pc_mem,
  input  logic            stall_mem,
  input  logic [1:0]      priv,
  input  logic            mstatus_mie,
  input  logic            mstatus_mpie,
  input  logic [1:0]      mstatus_mpp,
  input  logic [XLEN-1:0] mip,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            t_flush,
  output logic            busy,
  output logic            csr_we,
  output logic [XLEN-1:0] mepc_d,
  output logic [XLEN-1:0] mcause_d,
  output logic [XLEN-1:0] mtval_d,
  output logic            mstatus_mie_d,
  output logic            mstatus_mpie_d,
  output logic [1:0]      mstatus_mpp_d,
  output logic [1:0]      priv_d,
  output logic            pc_we,
  output logic [XLEN-1:0] pc_d
);

  trap_state_e     state_r;
  logic            ret_r;
  logic [XLEN-1:0] epc_r;
  logic [XLEN-1:0] cause_r;
  logic [XLEN-1:0] val_r;
  logic [XLEN-1:0] tgt_r;
  logic            mie_r;
  logic            mpie_r;
  logic [1:0]      mpp_r;
  logic [1:0]      priv_r;

  logic            irq_en_s;
  logic [XLEN-1:0] pend_s;
  logic            irq_valid_s;
  logic [5:0]      irq_code_s;
  logic [XLEN-1:0] base_s;
  logic [XLEN-1:0] irq_tgt_s;
  logic            accept_s;

  assign irq_en_s = mstatus_mie | (priv != PRIV_M);
  assign pend_s   = mip & mie;
  assign base_s   = {mtvec[XLEN-1:2], 2'b00};
  assign accept_s = !stall_mem & (exc | mret | irq_valid_s);

  trap_irq_prio u_prio (
    .pend  (pend_s),
    .en    (irq_en_s),
    .valid (irq_valid_s),
    .code  (irq_code_s)
  );

`ifdef TRAP_VECTORED_EN
  // Vectored mode offsets interrupt targets by 4*code; wraps modulo 2^64
  always_comb begin
    irq_tgt_s = base_s;
    if (mtvec[1:0] == 2'b01) begin
      irq_tgt_s = base_s + {56'd0, irq_code_s, 2'b00};
    end else begin
      irq_tgt_s = base_s;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^mtvec[1:0];

  // Direct mode: interrupts share the exception base
  always_comb begin
    irq_tgt_s = base_s;
  end
`endif

  // Sequencer: latch trap context in IDLE, then drive single-cycle registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      ret_r          <= 1'b0;
      epc_r          <= 64'd0;
      cause_r        <= 64'd0;
      val_r          <= 64'd0;
      tgt_r          <= 64'd0;
      mie_r          <= 1'b0;
      mpie_r         <= 1'b0;
      mpp_r          <= 2'd0;
      priv_r         <= 2'd0;
      t_flush        <= 1'b0;
      busy           <= 1'b0;
      csr_we         <= 1'b0;
      mepc_d         <= 64'd0;
      mcause_d       <= 64'd0;
      mtval_d        <= 64'd0;
      mstatus_mie_d  <= 1'b0;
      mstatus_mpie_d <= 1'b0;
      mstatus_mpp_d  <= 2'd0;
      priv_d         <= 2'd0;
      pc_we          <= 1'b0;
      pc_d           <= 64'd0;
    end else begin
      // Strobes are pulses and data is only meaningful under its strobe
      t_flush        <= 1'b0;
      csr_we         <= 1'b0;
      pc_we          <= 1'b0;
      mepc_d         <= 64'd0;
      mcause_d       <= 64'd0;
      mtval_d        <= 64'd0;
      mstatus_mie_d  <= 1'b0;
      mstatus_mpie_d <= 1'b0;
      mstatus_mpp_d  <= 2'd0;
      priv_d         <= 2'd0;
      pc_d           <= 64'd0;
      case (state_r)
        ST_IDLE: begin
          busy <= 1'b0;
          if (accept_s) begin
            state_r <= ST_FLUSH;
            t_flush <= 1'b1;
            busy    <= 1'b1;
            mie_r   <= mstatus_mie;
            mpie_r  <= mstatus_mpie;
            mpp_r   <= mstatus_mpp;
            priv_r  <= priv;
            if (exc) begin
              ret_r   <= 1'b0;
              epc_r   <= pc_mem;
              cause_r <= exc_cause;
              val_r   <= exc_val;
              tgt_r   <= base_s;
            end else if (mret) begin
              // mcause/mtval keep the last trap's values, i.e. the CSR contents
              ret_r   <= 1'b1;
              epc_r   <= mepc;
              tgt_r   <= mepc;
            end else begin
              // Interrupted instruction re-executes, so mepc is its own PC
              ret_r   <= 1'b0;
              epc_r   <= pc_mem;
              cause_r <= irq_cause(irq_code_s);
              val_r   <= 64'd0;
              tgt_r   <= irq_tgt_s;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          busy     <= 1'b1;
          csr_we   <= 1'b1;
          mepc_d   <= epc_r;
          mcause_d <= cause_r;
          mtval_d  <= val_r;
          if (ret_r) begin
            state_r        <= ST_RET;
            mstatus_mie_d  <= mpie_r;
            mstatus_mpie_d <= 1'b1;
            mstatus_mpp_d  <= PRIV_U;
            priv_d         <= mpp_r;
          end else begin
            state_r        <= ST_SAVE;
            mstatus_mie_d  <= 1'b0;
            mstatus_mpie_d <= mie_r;
            mstatus_mpp_d  <= priv_r;
            priv_d         <= PRIV_M;
          end
        end
        ST_SAVE, ST_RET: begin
          state_r <= ST_REDIR;
          busy    <= 1'b1;
          pc_we   <= 1'b1;
          pc_d    <= tgt_r;
        end
        ST_REDIR: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctl.sv
// tb_trap_ctl: directed scoreboard bench for trap_ctl.
module tb_trap_ctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exc = 1'b0;
  logic [63:0] exc_cause = 64'd0;
  logic [63:0] exc_val = 64'd0;
  logic        mret = 1'b0;
  logic [63:0] pc_mem = 64'd0;
  logic        stall_mem = 1'b0;
  logic [1:0]  priv = 2'd3;
  logic        mstatus_mie = 1'b0;
  logic        mstatus_mpie = 1'b0;
  logic [1:0]  mstatus_mpp = 2'd0;
  logic [63:0] mip = 64'd0;
  logic [63:0] mie = 64'd0;
  logic [63:0] mtvec = 64'd0;
  logic [63:0] mepc = 64'd0;
  logic        t_flush, busy, csr_we, pc_we;
  logic [63:0] mepc_d, mcause_d, mtval_d, pc_d;
  logic        mstatus_mie_d, mstatus_mpie_d;
  logic [1:0]  mstatus_mpp_d, priv_d;

  trap_ctl dut (
    .clk(clk), .rst_n(rst_n), .exc(exc), .exc_cause(exc_cause), .exc_val(exc_val),
    .mret(mret), .pc_mem(pc_mem), .stall_mem(stall_mem), .priv(priv),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie), .mstatus_mpp(mstatus_mpp),
    .mip(mip), .mie(mie), .mtvec(mtvec), .mepc(mepc),
    .t_flush(t_flush), .busy(busy), .csr_we(csr_we), .mepc_d(mepc_d),
    .mcause_d(mcause_d), .mtval_d(mtval_d), .mstatus_mie_d(mstatus_mie_d),
    .mstatus_mpie_d(mstatus_mpie_d), .mstatus_mpp_d(mstatus_mpp_d),
    .priv_d(priv_d), .pc_we(pc_we), .pc_d(pc_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [2:0]  kind;      // 1 flush, 2 csr write, 4 redirect
    logic [63:0] mepc;
    logic [63:0] mcause;
    logic [63:0] mtval;
    logic        chk_cause;
    logic        mie;
    logic        mpie;
    logic [1:0]  mpp;
    logic [1:0]  prv;
    logic [63:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc_cnt = 0;
  int   checks = 0;
  int   passes = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push_flush(input int c);
    exp_t e;
    e = '{c, 3'd1, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 64'd0};
    sb.push_back(e);
  endtask

  task automatic push_csr(input int c, input logic [63:0] ep, input logic [63:0] ca,
                          input logic [63:0] tv, input logic chk, input logic ie,
                          input logic pie, input logic [1:0] pp, input logic [1:0] pv);
    exp_t e;
    e = '{c, 3'd2, ep, ca, tv, chk, ie, pie, pp, pv, 64'd0};
    sb.push_back(e);
  endtask

  task automatic push_pc(input int c, input logic [63:0] p);
    exp_t e;
    e = '{c, 3'd4, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, p};
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single-cycle request pulse: inputs held across exactly one sampling edge
  task automatic pulse;
    step(1);
    exc = 1'b0; mret = 1'b0; mip = 64'd0;
  endtask

  // Output monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && (t_flush | csr_we | pc_we)) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {61'd0, pc_we, csr_we, t_flush}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_cycle", 64'(cyc_cnt), 64'(mon_e.cyc));
        check("strobe_kind", {61'd0, pc_we, csr_we, t_flush}, {61'd0, mon_e.kind});
        check("busy_in_seq", {63'd0, busy}, 64'd1);
        if (mon_e.kind == 3'd2) begin
          check("mepc_d", mepc_d, mon_e.mepc);
          if (mon_e.chk_cause) begin
            check("mcause_d", mcause_d, mon_e.mcause);
            check("mtval_d", mtval_d, mon_e.mtval);
          end
          check("mie_d", {63'd0, mstatus_mie_d}, {63'd0, mon_e.mie});
          check("mpie_d", {63'd0, mstatus_mpie_d}, {63'd0, mon_e.mpie});
          check("mpp_d", {62'd0, mstatus_mpp_d}, {62'd0, mon_e.mpp});
          check("priv_d", {62'd0, priv_d}, {62'd0, mon_e.prv});
        end
        if (mon_e.kind == 3'd4) begin
          check("pc_d", pc_d, mon_e.pc);
        end
      end
    end
  end

  logic [63:0] vec_mei, vec_msi;
  int c;

  initial begin
`ifdef TRAP_VECTORED_EN
    vec_mei = 64'h8000_002C;
    vec_msi = 64'h8000_000C;
`else
    vec_mei = 64'h8000_0000;
    vec_msi = 64'h8000_0000;
`endif
    // Reset state
    #3;
    check("rst_t_flush", {63'd0, t_flush}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_csr_we", {63'd0, csr_we}, 64'd0);
    check("rst_pc_we", {63'd0, pc_we}, 64'd0);
    check("rst_pc_d", pc_d, 64'd0);
    #20 rst_n = 1'b1;
    step(2);

    // Exception from U-mode
    priv = 2'd0; mstatus_mie = 1'b1; mtvec = 64'h8000_0000;
    exc = 1'b1; exc_cause = 64'd2; exc_val = 64'hdead; pc_mem = 64'h8000_0100;
    c = cyc_cnt;
    push_flush(c + 1);
    push_csr(c + 2, 64'h8000_0100, 64'd2, 64'hdead, 1'b1, 1'b0, 1'b1, 2'd0, 2'd3);
    push_pc(c + 3, 64'h8000_0000);
    pulse();
    step(5);
    check("busy_after_exc", {63'd0, busy}, 64'd0);

    // MEI + MTI pending in M-mode with MIE=1
    priv = 2'd3; mstatus_mie = 1'b1; mtvec = 64'h8000_0001; pc_mem = 64'h8000_0300;
    mip = 64'h880; mie = 64'h880;
    c = cyc_cnt;
    push_flush(c + 1);
    push_csr(c + 2, 64'h8000_0300, 64'h8000_0000_0000_000B, 64'd0, 1'b1, 1'b0, 1'b1, 2'd3, 2'd3);
    push_pc(c + 3, vec_mei);
    pulse();
    step(5);

    // MSI beats MTI; enabled by priv<M even with MIE=0
    priv = 2'd0; mstatus_mie = 1'b0; pc_mem = 64'h8000_0310;
    mip = 64'h88; mie = 64'h88;
    c = cyc_cnt;
    push_flush(c + 1);
    push_csr(c + 2, 64'h8000_0310, 64'h8000_0000_0000_0003, 64'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3);
    push_pc(c + 3, vec_msi);
    pulse();
    step(5);

    // MTI selected when only it is enabled
    priv = 2'd1; mstatus_mie = 1'b0; mtvec = 64'h8000_0000; pc_mem = 64'h8000_0320;
    mip = 64'h888; mie = 64'h080;
    c = cyc_cnt;
    push_flush(c + 1);
    push_csr(c + 2, 64'h8000_0320, 64'h8000_0000_0000_0007, 64'd0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd3);
    push_pc(c + 3, 64'h8000_0000);
    pulse();
    step(5);

    // Globally disabled interrupt and an ignored pending bit: no sequence
    priv = 2'd3; mstatus_mie = 1'b0; mip = 64'h800; mie = 64'h800;
    pulse();
    mstatus_mie = 1'b1; mip = 64'h2; mie = 64'h2;
    pulse();
    step(4);
    check("busy_no_irq", {63'd0, busy}, 64'd0);

    // mret back to U-mode
    mstatus_mie = 1'b0; mstatus_mpie = 1'b1; mstatus_mpp = 2'd0; priv = 2'd3;
    mepc = 64'h8000_0200; mret = 1'b1;
    c = cyc_cnt;
    push_flush(c + 1);
    push_csr(c + 2, 64'h8000_0200, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
    push_pc(c + 3, 64'h8000_0200);
    pulse();
    step(5);

    // exc + mret + MTI together; second mret/irq pulse while busy is dropped
    mstatus_mie = 1'b1; mtvec = 64'h8000_0000; priv = 2'd3;
    exc = 1'b1; exc_cause = 64'd5; exc_val = 64'h1234; pc_mem = 64'h8000_0400;
    mret = 1'b1; mip = 64'h80; mie = 64'h80;
    c = cyc_cnt;
    push_flush(c + 1);
    push_csr(c + 2, 64'h8000_0400, 64'd5, 64'h1234, 1'b1, 1'b0, 1'b1, 2'd3, 2'd3);
    push_pc(c + 3, 64'h8000_0000);
    pulse();
    mret = 1'b1; mip = 64'h80;
    pulse();
    step(5);

    // Stalled exception waits for the stall to drop
    stall_mem = 1'b1; exc = 1'b1; exc_cause = 64'd7; exc_val = 64'h55; pc_mem = 64'h8000_0500;
    priv = 2'd0; mstatus_mie = 1'b0; mtvec = 64'h8000_0104;
    step(3);
    check("busy_stalled", {63'd0, busy}, 64'd0);
    stall_mem = 1'b0;
    c = cyc_cnt;
    push_flush(c + 1);
    push_csr(c + 2, 64'h8000_0500, 64'd7, 64'h55, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3);
    push_pc(c + 3, 64'h8000_0104);
    pulse();
    step(5);

    // Reset asserted during SAVE: async clear, no later csr/pc strobes
    exc = 1'b1; exc_cause = 64'd4; pc_mem = 64'h8000_0600;
    c = cyc_cnt;
    push_flush(c + 1);
    pulse();
    step(1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_csr_we", {63'd0, csr_we}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_mepc_d", mepc_d, 64'd0);
    check("rst_mid_mcause_d", mcause_d, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(6);
    check("busy_after_rst", {63'd0, busy}, 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
